mux_select_round_robin_controller: RTL and testbench



---
 rtl/mux_select_round_robin_controller.sv | 157 +++++++++++++++
 tb/tb_mux_select_round_robin_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_select_round_robin_controller.sv
// mux_select_round_robin_controller
// Round-robin select generator for a 4:1 mux. It grants one of four requesters,
// holds s1/s0 stable until the consumer acks, then advances the fairness pointer.
// Optional feature macro: SEL_TIMEOUT_EN enables a watchdog that force-releases
// a grant after TIMEOUT cycles without ack and pulses `timeout` for one cycle.
// Without the macro, `timeout` is tied low and TIMEOUT is unused.

module mux_select_round_robin_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic [3:0] grant,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q,  last_d;
    logic [1:0] sel_q,   sel_d;
    logic       valid_q, valid_d;
    logic [3:0] grant_q, grant_d;

`ifdef SEL_TIMEOUT_EN
    // Counter value seen during the last allowed GRANT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q,     cnt_d;
    logic       timeout_q, timeout_d;
`else
    // Parameter kept for interface compatibility only.
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT > 0);
`endif

    // Candidate indices in fairness order: last+1, last+2, last+3, last.
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic       pick_valid;
    logic [1:0] pick_idx;

    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
        assign cand_idx[gi] = last_q + 2'(gi + 1);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    // Pick the earliest candidate in fairness order that is requesting.
    always_comb begin
        pick_valid = |cand_hit;
        pick_idx   = cand_idx[0];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // Next-state logic for the IDLE/GRANT controller and its registered outputs.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        grant_d = grant_q;
`ifdef SEL_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Selects hold their last value while idle to avoid mux glitches.
                valid_d = 1'b0;
                grant_d = 4'b0000;
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    grant_d = 4'b0001 << pick_idx;
                    state_d = ST_GRANT;
`ifdef SEL_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            ST_GRANT: begin
                // req changes are ignored here; only ack (or the watchdog) releases.
                if (ack) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    last_d  = sel_q;
                end
`ifdef SEL_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    // Stuck source loses its turn, same as an ack would.
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    grant_d   = 4'b0000;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            grant_q <= 4'b0000;
`ifdef SEL_TIMEOUT_EN
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
`ifdef SEL_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign valid = valid_q;
    assign grant = grant_q;
`ifdef SEL_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_select_round_robin_controller.sv
// Testbench for mux_select_round_robin_controller: directed steps followed by
// random traffic, every cycle compared against a behavioural reference model.

module tb_mux_select_round_robin_controller;

`ifdef SEL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ack = 1'b0;
    logic       s0, s1, valid, timeout;
    logic [3:0] grant;

    int total = 0;
    int bad   = 0;

    // Reference model: who is granted, who went last, how long we have waited.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_last = 3;
    int m_wait = 0;
    bit m_to   = 1'b0;

    always #5 clk = ~clk;

    mux_select_round_robin_controller #(.TIMEOUT(TO_CYC)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .ack     (ack),
        .s0      (s0),
        .s1      (s1),
        .valid   (valid),
        .grant   (grant),
        .timeout (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge(input bit r, input logic [3:0] rq, input bit a);
        if (r) begin
            m_busy = 1'b0; m_sel = 0; m_last = 3; m_wait = 0; m_to = 1'b0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_last + k) % 4;
                if (!m_busy && rq[idx]) begin
                    m_busy = 1'b1;
                    m_sel  = idx;
                    m_wait = 0;
                end
            end
        end else begin
            m_to = 1'b0;
            if (a) begin
                m_busy = 1'b0;
                m_last = m_sel;
            end else begin
                m_wait++;
                if (TO_EN && m_wait == TO_CYC) begin
                    m_busy = 1'b0;
                    m_last = m_sel;
                    m_to   = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input logic [3:0] rq, input bit a);
        reset = r; req = rq; ack = a;
        @(posedge clk);
        model_edge(r, rq, a);
        #1;
        chk("s1s0",    32'({s1, s0}), 32'(m_busy ? m_sel : m_sel));
        chk("valid",   32'(valid),    32'(m_busy));
        chk("grant",   32'(grant),    m_busy ? (32'd1 << m_sel) : 32'd0);
        chk("timeout", 32'(timeout),  32'(m_to));
        $display("t=%0t rst=%0b req=%b ack=%0b -> s1s0=%0d valid=%0b grant=%b timeout=%0b",
                 $time, r, rq, a, {s1, s0}, valid, grant, timeout);
    endtask

    initial begin
        // Reset with all requests raised.
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel",   32'({s1, s0}), 32'd0);
        chk("rst_to",    32'(timeout), 32'd0);

        // Round robin with all requesters active.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, 1'b0);
            chk("rr_grant", 32'(grant), 32'd1 << (k % 4));
            chk("rr_sel",   32'({s1, s0}), 32'(k % 4));
            step(1'b0, 4'b1111, 1'b1);
        end

        // Fairness skip: get last=1, then req=1001 -> index 3 then 0.
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        chk("skip_grant3", 32'(grant), 32'b1000);
        step(1'b0, 4'b1001, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        chk("skip_grant0", 32'(grant), 32'b0001);
        step(1'b0, 4'b0000, 1'b1);

        // Hold stability: grant index 2, requests drop, no ack.
        step(1'b0, 4'b0100, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Watchdog: grant index 1 and never ack, index 2 waiting.
        step(1'b0, 4'b0010, 1'b0);
        for (int k = 0; k < TO_CYC + 2; k++) step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // Watchdog race: ack arrives in the last allowed cycle.
        step(1'b0, 4'b0010, 1'b0);
        for (int k = 0; k < TO_CYC - 1; k++) step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Reset while granted with ack high; next grant must be index 0.
        step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b1111, 1'b1);
        chk("midrst_valid", 32'(valid), 32'd0);
        step(1'b0, 4'b1111, 1'b0);
        chk("midrst_grant", 32'(grant), 32'b0001);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bit          r, a;
            logic [3:0]  rq;
            r  = ($urandom_range(0, 99) < 2);
            a  = ($urandom_range(0, 99) < 35);
            rq = 4'($urandom_range(0, 15));
            step(r, rq, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
